// File: rtl/ascii_seq_pkg.sv
// Shared definitions for the ASCII sequence generator.
// Contents:
//   state_t                      controller state encoding (IDLE, SEND, GAP, FIN)
//   ASCII_1 / ASCII_2 / ASCII_3  default characters of the sequence ("123")
//   ASCII_NUL                    value driven on ascii whenever valid is low
package ascii_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [6:0] ASCII_1   = 7'h31;
    localparam logic [6:0] ASCII_2   = 7'h32;
    localparam logic [6:0] ASCII_3   = 7'h33;
    localparam logic [6:0] ASCII_NUL = 7'h00;

endpackage

// File: rtl/ascii_seq_gen_gap_timer.sv
// Loadable down-counter that times the idle gap between passes.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset (count cleared to 0)
//   load      loads load_val into the counter (takes priority over en)
//   load_val  value loaded; the gap lasts load_val+1 cycles
//   en        decrements the counter while it is non-zero
//   expired   high while the count is zero
module gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ascii_seq_gen.sv
// Transmit side of the ASCII sequence-recognition path.
// On an accepted start, sends CHAR0,CHAR1,CHAR2 repeat_cnt times over a
// valid/ready handshake, with GAP_CYCLES idle cycles between passes, then
// pulses done for one cycle.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       one-cycle burst request, sampled only in IDLE
//   repeat_cnt  number of passes, latched when start is accepted
//   ready       downstream accepts ascii this cycle
//   ascii       current character, 7'h00 while valid is low
//   valid       ascii holds a character awaiting transfer
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last transfer (or an empty burst)
module ascii_seq_gen
    import ascii_seq_pkg::*;
#(
    parameter logic [6:0] CHAR0      = ASCII_1,
    parameter logic [6:0] CHAR1      = ASCII_2,
    parameter logic [6:0] CHAR2      = ASCII_3,
    parameter int         GAP_CYCLES = 2,
    parameter int         CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             ready,
    output logic [6:0]       ascii,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    // Timer holds GAP_CYCLES-1 so that GAP lasts exactly GAP_CYCLES cycles.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] passes, passes_nxt;
    logic             tmr_load, tmr_en, tmr_expired;
    logic             xfer;

    function automatic logic [6:0] char_sel(input logic [1:0] i);
        case (i)
            2'd0:    return CHAR0;
            2'd1:    return CHAR1;
            default: return CHAR2;
        endcase
    endfunction

    // valid is only ever high in SEND, so this is the handshake edge.
    assign xfer = valid && ready;

    gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (GAP_LOAD),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        passes_nxt = passes;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (repeat_cnt != '0) begin
                        passes_nxt = repeat_cnt;
                        idx_nxt    = 2'd0;
                        state_nxt  = SEND;
                    end else begin
                        state_nxt  = FIN;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx == 2'd2) begin
                        idx_nxt    = 2'd0;
                        passes_nxt = passes - CNT_W'(1);
                        if (passes == CNT_W'(1)) begin
                            state_nxt = FIN;
                        end else if (GAP_CYCLES == 0) begin
                            state_nxt = SEND;
                        end else begin
                            state_nxt = GAP;
                            tmr_load  = 1'b1;
                        end
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            GAP: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_nxt = SEND;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe; ready=0 leaves everything unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            passes <= '0;
            ascii  <= ASCII_NUL;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            passes <= passes_nxt;
            valid  <= (state_nxt == SEND);
            ascii  <= (state_nxt == SEND) ? char_sel(idx_nxt) : ASCII_NUL;
            busy   <= (state_nxt != IDLE);
            done   <= (state_nxt == FIN);
        end
    end

endmodule

// File: tb/tb_ascii_seq_gen.sv
module tb_ascii_seq_gen;

    typedef struct {
        logic [3:0] cnt;
        logic [7:0] pat;
        int         exp_done;
        int         exp_gap;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] repeat_cnt = 4'd0;
    logic       ready = 1'b0;
    logic [6:0] ascii;
    logic       valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    logic [6:0] exp_q[$];

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [6:0] pa = 7'h00;

    vec_t vecs[6];

    ascii_seq_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .ready      (ready),
        .ascii      (ascii),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitor: a transfer happens on the next rising edge when
    // valid and ready are both high at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", valid, 1);
                chk("hold_ascii", ascii, pa);
            end
            if (!valid) chk("nul_when_invalid", ascii, 0);
            if (valid && ready) begin
                xfer_cnt++;
                chk("xfer_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("xfer_char", ascii, exp_q.pop_front());
            end
            pv = valid;
            pr = ready;
            pa = ascii;
        end
    end

    task automatic burst(input logic [3:0] cnt, input logic [7:0] pat,
                         input int exp_done, input int exp_gap, input bit extra);
        int x0, done_k, dones, gaps;
        x0 = xfer_cnt;
        done_k = -1;
        dones = 0;
        gaps = 0;
        for (int p = 0; p < int'(cnt); p++) begin
            exp_q.push_back(7'h31);
            exp_q.push_back(7'h32);
            exp_q.push_back(7'h33);
        end
        start = 1'b1;
        repeat_cnt = cnt;
        ready = pat[0];
        for (int k = 1; k <= 300; k++) begin
            step();
            start = 1'b0;
            ready = pat[k % 8];
            if (done_k >= 0) begin
                chk("done_one_cycle", done, 0);
                chk("idle_after_done", busy, 0);
                break;
            end
            if (done) begin
                dones++;
                done_k = k;
                if (extra) start = 1'b1;
            end else if (busy && !valid) begin
                gaps++;
            end
            if (extra && busy && !done && (k % 3 == 0)) begin
                start = 1'b1;
                repeat_cnt = 4'd7;
            end
        end
        start = 1'b0;
        repeat (4) step();
        chk("stay_idle", busy, 0);
        chk("done_seen", dones, 1);
        if (exp_done >= 0) chk("done_latency", done_k, exp_done);
        chk("gap_cycles", gaps, exp_gap);
        chk("xfer_total", xfer_cnt - x0, int'(cnt) * 3);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{cnt: 4'd1,  pat: 8'hFF, exp_done: 4,  exp_gap: 0};
        vecs[1] = '{cnt: 4'd2,  pat: 8'hFF, exp_done: 9,  exp_gap: 2};
        vecs[2] = '{cnt: 4'd1,  pat: 8'hE8, exp_done: 7,  exp_gap: 0};
        vecs[3] = '{cnt: 4'd0,  pat: 8'hFF, exp_done: 1,  exp_gap: 0};
        vecs[4] = '{cnt: 4'd3,  pat: 8'hAA, exp_done: -1, exp_gap: 4};
        vecs[5] = '{cnt: 4'd15, pat: 8'hFF, exp_done: 74, exp_gap: 28};

        #1;
        chk("rst_valid", valid, 0);
        chk("rst_ascii", ascii, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            burst(vecs[i].cnt, vecs[i].pat, vecs[i].exp_done, vecs[i].exp_gap, 1'b0);
        end

        // Asynchronous reset in the middle of a pass, after '2' is taken.
        begin
            int x0;
            x0 = xfer_cnt;
            exp_q.push_back(7'h31);
            exp_q.push_back(7'h32);
            exp_q.push_back(7'h33);
            start = 1'b1;
            repeat_cnt = 4'd1;
            ready = 1'b1;
            step();
            start = 1'b0;
            step();
            step();
            reset = 1'b1;
            exp_q.delete();
            #1;
            chk("midrst_valid", valid, 0);
            chk("midrst_ascii", ascii, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_done", done, 0);
            chk("midrst_xfers", xfer_cnt - x0, 2);
            step();
            reset = 1'b0;
            step();
            chk("after_rst_idle", busy, 0);
            burst(4'd1, 8'hFF, 4, 0, 1'b0);
        end

        // Start pulses while busy and on the done cycle are ignored.
        burst(4'd2, 8'hFF, 9, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
